// File: rtl/wb_uart_defs.sv
// Shared definitions for wb_uart: register offsets, STATUS bit positions and
// the 2-bit state encoding used by both the TX and RX serial engines.
package wb_uart_defs;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_IDLE  = 2;
    localparam int ST_RXOVF    = 3;
    localparam int ST_FERR     = 4;
    localparam int ST_TXOVF    = 5;
    localparam int ST_LOOP     = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/wb_uart_fifo.sv
// Synchronous FIFO of 2**ABITS entries. A pop on empty is ignored; a push on
// full only succeeds when a pop frees a slot in the same cycle.
module wb_uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ABITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned    DEPTH    = 1 << ABITS;
    localparam logic [ABITS:0] FULL_CNT = (ABITS + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ABITS-1:0] wr_q, rd_q;
    logic [ABITS:0]   count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + ABITS'(1);
            if (do_pop)  rd_q <= rd_q + ABITS'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (ABITS + 1)'(1);
                2'b01:   count_q <= count_q - (ABITS + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart.sv
// 8N1 UART behind a zero-wait-state Wishbone classic slave (DATA / STATUS).
// Optional WB_UART_LOOPBACK_EN adds STATUS.LOOP routing internal txd to RX.
module wb_uart
    import wb_uart_defs::*;
#(
    parameter int unsigned DIVISOR    = 434,
    parameter int unsigned FIFO_ABITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        txd,
    input  logic        rxd
);
    localparam logic [15:0] DIV_M1  = 16'(DIVISOR - 1);
    localparam logic [15:0] HALF_M1 = 16'(DIVISOR / 2 - 1);

    logic acc, wr_data, rd_data, wr_status;
    assign acc       = stb_i & cyc_i;
    assign ack_o     = acc;
    assign wr_data   = acc & we_i & (adr_i[0] == REG_DATA) & sel_i[0];
    assign rd_data   = acc & ~we_i & (adr_i[0] == REG_DATA);
    assign wr_status = acc & we_i & (adr_i[0] == REG_STATUS);

    logic unused_bits;
    assign unused_bits = ^{adr_i[31:1], dat_i[31:8], sel_i[3:1]};

    logic       tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_full, rx_empty;
    logic [7:0] rx_head;

    uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] tx_baud_q, tx_baud_d, rx_baud_q, rx_baud_d;
    logic [2:0]  tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic        txd_q, txd_d;
    logic [1:0]  sync_q;
    logic        rx_in, rx_s, tx_tick, rx_tick, ferr_set;
    logic        rxovf_q, rxovf_d, ferr_q, ferr_d, txovf_q, txovf_d;
    logic [31:0] status;

    wb_uart_fifo #(.WIDTH(8), .ABITS(FIFO_ABITS)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (wr_data),
        .data_i (dat_i[7:0]),
        .pop_i  (tx_pop),
        .head_o (tx_head),
        .full_o (tx_full),
        .empty_o(tx_empty)
    );

    wb_uart_fifo #(.WIDTH(8), .ABITS(FIFO_ABITS)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (rx_push),
        .data_i (rx_shift_q),
        .pop_i  (rd_data),
        .head_o (rx_head),
        .full_o (rx_full),
        .empty_o(rx_empty)
    );

`ifdef WB_UART_LOOPBACK_EN
    logic loop_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         loop_q <= 1'b0;
        else if (wr_status) loop_q <= dat_i[ST_LOOP];
    end
    assign rx_in = loop_q ? txd_q : rxd;
`else
    assign rx_in = rxd;
`endif

    assign rx_s    = sync_q[1];
    assign txd     = txd_q;
    assign tx_tick = (tx_baud_q == 16'd0);
    assign rx_tick = (rx_baud_q == 16'd0);

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_idx_d   = tx_idx_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        tx_baud_d  = (tx_state_q == S_IDLE) ? tx_baud_q
                   : (tx_tick ? DIV_M1 : tx_baud_q - 16'd1);
        case (tx_state_q)
            S_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_head;
                tx_baud_d  = DIV_M1;
                tx_state_d = S_START;
                txd_d      = 1'b0;
            end
            S_START: if (tx_tick) begin
                tx_state_d = S_DATA;
                tx_idx_d   = 3'd0;
                txd_d      = tx_shift_q[0];
            end
            S_DATA: if (tx_tick) begin
                if (tx_idx_q == 3'd7) begin
                    tx_state_d = S_STOP;
                    txd_d      = 1'b1;
                end else begin
                    tx_idx_d   = tx_idx_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    txd_d      = tx_shift_q[1];
                end
            end
            S_STOP: if (tx_tick) begin
                // Chain straight into the next START so queued bytes leave no idle gap.
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = S_START;
                    txd_d      = 1'b0;
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_idx_d   = rx_idx_q;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        rx_baud_d  = (rx_state_q == S_IDLE) ? rx_baud_q
                   : (rx_tick ? DIV_M1 : rx_baud_q - 16'd1);
        case (rx_state_q)
            S_IDLE: if (!rx_s) begin
                rx_state_d = S_START;
                rx_baud_d  = HALF_M1;
            end
            S_START: if (rx_tick) begin
                rx_idx_d   = 3'd0;
                rx_state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_tick) begin
                rx_shift_d = {rx_s, rx_shift_q[7:1]};
                if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
                else                  rx_idx_d   = rx_idx_q + 3'd1;
            end
            S_STOP: if (rx_tick) begin
                rx_push    = rx_s;
                ferr_set   = ~rx_s;
                rx_state_d = S_IDLE;
            end
        endcase
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    always_comb begin
        txovf_d = (txovf_q & ~(wr_status & dat_i[ST_TXOVF])) | (wr_data & tx_full & ~tx_pop);
        rxovf_d = (rxovf_q & ~(wr_status & dat_i[ST_RXOVF])) | (rx_push & rx_full & ~rd_data);
        ferr_d  = (ferr_q  & ~(wr_status & dat_i[ST_FERR]))  | ferr_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= S_IDLE;
            tx_baud_q  <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_baud_q  <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            sync_q     <= 2'b11;
            txovf_q    <= 1'b0;
            rxovf_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            sync_q     <= {sync_q[0], rx_in};
            txovf_q    <= txovf_d;
            rxovf_q    <= rxovf_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        status              = '0;
        status[ST_RX_VALID] = ~rx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_IDLE]  = tx_empty & (tx_state_q == S_IDLE);
        status[ST_RXOVF]    = rxovf_q;
        status[ST_FERR]     = ferr_q;
        status[ST_TXOVF]    = txovf_q;
`ifdef WB_UART_LOOPBACK_EN
        status[ST_LOOP]     = loop_q;
`endif
    end

    // Wired-OR slave bus: drive zero unless this slave is addressed.
    always_comb begin
        dat_o = '0;
        if (acc) begin
            if (adr_i[0] == REG_STATUS) dat_o = status;
            else                        dat_o = {24'h0, rx_empty ? 8'h00 : rx_head};
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Self-checking bench for wb_uart (DIVISOR=8, FIFO_ABITS=3): a txd line monitor
// checks frames against an expected-byte queue; RX bytes are queued and popped on reads.
module tb_wb_uart;
    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] adr_i = '0, dat_i = '0, dat_o;
    logic        we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0, ack_o, txd, rxd = 1'b1;
    logic [3:0]  sel_i = '0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         tx_starts[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc_cnt = 0;
    bit         mon_en = 1'b0;

    wb_uart #(.DIVISOR(DIV), .FIFO_ABITS(3)) dut (
        .clk(clk), .reset(reset), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
        .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "time limit");
    end

    // txd line monitor: samples mid-bit on falling clock edges.
    initial begin : tx_monitor
        logic [7:0] mon_byte;
        logic [7:0] mon_want;
        bit         mon_ok;
        int         mon_start;
        forever begin
            @(negedge clk);
            if (mon_en && reset && txd === 1'b0) begin
                mon_start = cyc_cnt;
                mon_ok    = 1'b1;
                mon_byte  = '0;
                for (int k = 1; k <= 75; k++) begin
                    @(negedge clk);
                    if (!mon_en || !reset) begin
                        mon_ok = 1'b0;
                        break;
                    end
                    if (k == 3) begin
                        n_checks++;
                        if (txd !== 1'b0) begin
                            n_fail++;
                            $display("FAIL tx_start_bit: got %b, expected 0", txd);
                        end
                    end else if (k == 75) begin
                        n_checks++;
                        if (txd !== 1'b1) begin
                            n_fail++;
                            $display("FAIL tx_stop_bit: got %b, expected 1", txd);
                        end
                    end else if (k % 8 == 3) begin
                        mon_byte[k/8 - 1] = txd;
                    end
                end
                if (mon_ok) begin
                    n_checks++;
                    if (tx_exp.size() == 0) begin
                        n_fail++;
                        $display("FAIL tx_frame: got 0x%02h, expected no frame", mon_byte);
                    end else begin
                        mon_want = tx_exp.pop_front();
                        if (mon_byte !== mon_want) begin
                            n_fail++;
                            $display("FAIL tx_frame: got 0x%02h, expected 0x%02h", mon_byte, mon_want);
                        end
                    end
                    tx_starts.push_back(mon_start);
                end
            end
        end
    end

    task automatic bus_idle();
        adr_i = '0; dat_i = '0; sel_i = '0; we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
    endtask

    task automatic wb_write(input logic a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        adr_i = {31'h0, a}; dat_i = d; sel_i = s; we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic wb_read(input logic a, output logic [31:0] d);
        @(negedge clk);
        adr_i = {31'h0, a}; dat_i = '0; sel_i = 4'hF; we_i = 1'b0; stb_i = 1'b1; cyc_i = 1'b1;
        #1 d = dat_o;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            rxd = b[j];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_tx_drain(input int budget);
        for (int c = 0; c < budget && tx_exp.size() != 0; c++) @(negedge clk);
        n_checks++;
        if (tx_exp.size() != 0) begin
            n_fail++;
            $display("FAIL tx_drain_timeout: got %0d pending, expected 0", tx_exp.size());
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        n_checks++;
        if (txd !== 1'b1 || ack_o !== 1'b0 || dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got txd=%b ack=%b dat=0x%08h, expected 1 0 0", txd, ack_o, dat_o);
        end
        reset = 1'b1;
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL reset_status: got 0x%08h, expected 0x00000004", d);
        end
        wb_read(1'b0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got 0x%08h, expected 0x00000000", d);
        end
    endtask

    task automatic test_tx_basic();
        logic [31:0] d;
        logic [9:0]  frame;
        frame = {1'b1, 8'hA5, 1'b0};
        mon_en = 1'b1;
        tx_exp.push_back(8'hA5);
        wb_write(1'b0, 32'h0000_00A5, 4'hF);
        n_checks++;
        if (txd !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_latency: got txd=%b right after write, expected 1", txd);
        end
        for (int i = 0; i < 10 * DIV; i++) begin
            @(negedge clk);
            n_checks++;
            if (txd !== frame[i / DIV]) begin
                n_fail++;
                $display("FAIL tx_waveform[%0d]: got %b, expected %b", i, txd, frame[i / DIV]);
            end
        end
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL tx_idle_after: got 0x%08h, expected 0x00000004", d);
        end
    endtask

    task automatic test_bus();
        logic [31:0] d;
        @(negedge clk);
        adr_i = 32'h1; we_i = 1'b0; sel_i = 4'hF;
        cyc_i = 1'b1; stb_i = 1'b0;
        #1;
        n_checks++;
        if (ack_o !== 1'b0 || dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL bus_stb_low: got ack=%b dat=0x%08h, expected 0 0", ack_o, dat_o);
        end
        @(negedge clk);
        cyc_i = 1'b0; stb_i = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 1'b0 || dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL bus_cyc_low: got ack=%b dat=0x%08h, expected 0 0", ack_o, dat_o);
        end
        @(negedge clk);
        cyc_i = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 1'b1 || dat_o !== 32'h4) begin
            n_fail++;
            $display("FAIL bus_selected: got ack=%b dat=0x%08h, expected 1 0x00000004", ack_o, dat_o);
        end
        @(negedge clk);
        bus_idle();
        wb_write(1'b0, 32'h0000_0077, 4'b1110);
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL bus_sel_no_push: got 0x%08h, expected 0x00000004", d);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (txd !== 1'b1) begin
            n_fail++;
            $display("FAIL bus_sel_txd: got %b, expected 1", txd);
        end
    endtask

    task automatic test_tx_fifo_full();
        logic [31:0] d;
        tx_starts.delete();
        tx_exp.push_back(8'h11);
        wb_write(1'b0, 32'h11, 4'hF);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            adr_i = '0; dat_i = 32'h20 + i; sel_i = 4'hF; we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
            if (i < 8) tx_exp.push_back(8'(8'h20 + i));
        end
        @(negedge clk);
        bus_idle();
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h22) begin
            n_fail++;
            $display("FAIL txovf_status: got 0x%08h, expected 0x00000022", d);
        end
        wait_tx_drain(1500);
        n_checks++;
        if (tx_starts.size() != 9) begin
            n_fail++;
            $display("FAIL tx_frame_count: got %0d, expected 9", tx_starts.size());
        end
        for (int i = 1; i < tx_starts.size(); i++) begin
            n_checks++;
            if (tx_starts[i] - tx_starts[i-1] != 10 * DIV) begin
                n_fail++;
                $display("FAIL tx_gap[%0d]: got %0d cycles, expected %0d", i, tx_starts[i] - tx_starts[i-1], 10 * DIV);
            end
        end
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h24) begin
            n_fail++;
            $display("FAIL txovf_sticky: got 0x%08h, expected 0x00000024", d);
        end
        wb_write(1'b1, 32'h20, 4'hF);
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL txovf_clear: got 0x%08h, expected 0x00000004", d);
        end
    endtask

    task automatic test_rx_basic();
        logic [31:0] d;
        logic [7:0]  e;
        rx_exp.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h5) begin
            n_fail++;
            $display("FAIL rx_valid_set: got 0x%08h, expected 0x00000005", d);
        end
        e = rx_exp.pop_front();
        wb_read(1'b0, d);
        n_checks++;
        if (d !== {24'h0, e}) begin
            n_fail++;
            $display("FAIL rx_data: got 0x%08h, expected 0x%08h", d, {24'h0, e});
        end
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL rx_valid_clear: got 0x%08h, expected 0x00000004", d);
        end
        wb_read(1'b0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL rx_empty_read: got 0x%08h, expected 0x00000000", d);
        end
    endtask

    task automatic test_rx_ferr();
        logic [31:0] d;
        send_frame(8'h99, 1'b0);
        repeat (16) @(negedge clk);
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h14) begin
            n_fail++;
            $display("FAIL rx_ferr: got 0x%08h, expected 0x00000014", d);
        end
        wb_write(1'b1, 32'h10, 4'hF);
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL rx_ferr_clear: got 0x%08h, expected 0x00000004", d);
        end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] d;
        logic [7:0]  e;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) rx_exp.push_back(8'(8'h40 + 3 * i));
            send_frame(8'(8'h40 + 3 * i), 1'b1);
        end
        repeat (2) @(negedge clk);
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'hD) begin
            n_fail++;
            $display("FAIL rxovf_status: got 0x%08h, expected 0x0000000d", d);
        end
        while (rx_exp.size() != 0) begin
            e = rx_exp.pop_front();
            wb_read(1'b0, d);
            n_checks++;
            if (d !== {24'h0, e}) begin
                n_fail++;
                $display("FAIL rxovf_data: got 0x%08h, expected 0x%08h", d, {24'h0, e});
            end
        end
        wb_read(1'b0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL rxovf_drained: got 0x%08h, expected 0x00000000", d);
        end
        wb_write(1'b1, 32'h08, 4'hF);
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL rxovf_clear: got 0x%08h, expected 0x00000004", d);
        end
    endtask

    task automatic test_rx_glitch();
        logic [31:0] d;
        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL rx_glitch: got 0x%08h, expected 0x00000004", d);
        end
    endtask

    task automatic test_loopback();
        logic [31:0] d;
`ifdef WB_UART_LOOPBACK_EN
        logic [7:0] e;
        wb_write(1'b1, 32'h40, 4'hF);
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h44) begin
            n_fail++;
            $display("FAIL loop_bit: got 0x%08h, expected 0x00000044", d);
        end
        tx_exp.push_back(8'h5A);
        rx_exp.push_back(8'h5A);
        wb_write(1'b0, 32'h5A, 4'hF);
        repeat (10 * DIV + 4) @(negedge clk);
        e = rx_exp.pop_front();
        wb_read(1'b0, d);
        n_checks++;
        if (d !== {24'h0, e}) begin
            n_fail++;
            $display("FAIL loop_data: got 0x%08h, expected 0x%08h", d, {24'h0, e});
        end
        wait_tx_drain(200);
        wb_write(1'b1, 32'h0, 4'hF);
`else
        wb_write(1'b1, 32'h40, 4'hF);
`endif
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL loop_off_status: got 0x%08h, expected 0x00000004", d);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        mon_en = 1'b0;
        send_frame(8'h81, 1'b1);
        wb_write(1'b0, 32'h00, 4'hF);
        wb_write(1'b0, 32'h55, 4'hF);
        repeat (20) @(negedge clk);
        n_checks++;
        if (txd !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_frame_txd: got %b, expected 0", txd);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (txd !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_txd: got %b, expected 1", txd);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wb_read(1'b1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL reset_mid_status: got 0x%08h, expected 0x00000004", d);
        end
        wb_read(1'b0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_rxdata: got 0x%08h, expected 0x00000000", d);
        end
        repeat (100) @(negedge clk);
        n_checks++;
        if (txd !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_txd_idle: got %b, expected 1", txd);
        end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_tx_basic();
        test_bus();
        test_tx_fifo_full();
        test_rx_basic();
        test_rx_ferr();
        test_rx_overflow();
        test_rx_glitch();
        test_loopback();
        test_reset_mid_frame();
        n_checks++;
        if (tx_exp.size() != 0 || rx_exp.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got tx=%0d rx=%0d, expected 0 0", tx_exp.size(), rx_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_uart.md
Name: wb_uart

Overview:
- Synthesizable 8N1 UART, Wishbone classic slave.
- Replaces the simulation-only serial device on the data-bus mux slot at 0x00000020 (mask 0xfffffffe, 2 words).
- Consumes the mux's per-slave strobe/cycle/address/data. Returns read data on the wired-OR slave data bus.
- Buffers TX and RX bytes in small FIFOs so the core never stalls on the line rate.

Parameters:
- DIVISOR, 434, core clocks per bit (50 MHz / 115200); legal range 4..65535.
- FIFO_ABITS, 3, log2 depth of each FIFO (8 entries).

Ports:
- clk  in  1  core clock (clk_core domain).
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- adr_i  in  32  word address; only bit 0 decoded (0=DATA, 1=STATUS).
- dat_i  in  32  write data.
- dat_o  out  32  read data; all-zero whenever stb_i&cyc_i is low (wired-OR bus).
- we_i  in  1  write enable.
- sel_i  in  4  byte selects; DATA write requires sel_i[0].
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle.
- ack_o  out  1  equals stb_i&cyc_i, combinational, zero wait states.
- txd  out  1  serial out, idle high.
- rxd  in  1  serial in, asynchronous to clk.

Behaviour:
- Reset (reset==0): FIFOs empty, both FSMs IDLE, baud counters 0, sticky flags 0, txd=1, rxd synchronizer flops=1. dat_o/ack_o follow their combinational definitions (0 when not selected).
- Access `acc` = stb_i&cyc_i. Side effects take place on the rising edge where acc is high. Reads are combinational from current state.
- DATA write: push dat_i[7:0] to the TX FIFO if sel_i[0] and not full. If full, drop the byte and set TXOVF.
- DATA read: dat_o={24'b0, rx head byte}. Pop if not empty. If empty, return 0 with no pop.
- STATUS read bits:
  - [0] rx_valid
  - [1] tx_full
  - [2] tx_idle (TX FIFO empty and TX FSM IDLE)
  - [3] RXOVF
  - [4] FERR
  - [5] TXOVF
  - [31:6] read as 0.
- STATUS write: W1C on bits 3..5; other bits ignored.
- Sticky set and W1C clear in the same cycle: set wins.
- FIFO push and pop in the same cycle:
  - Both occur when the FIFO is neither empty nor full.
  - Full + pop + push: both succeed, count unchanged.
  - Empty + push + pop: pop ignored, push succeeds.
- Pointers wrap modulo 2^FIFO_ABITS. Count is FIFO_ABITS+1 bits wide.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: when FIFO not empty, pop into shift register, load baud counter with DIVISOR-1, go to START (txd=0).
  - Each state lasts exactly DIVISOR clocks; the counter reloads at 0.
  - DATA shifts LSB first over 8 bits, tracked by a 3-bit index.
  - STOP drives txd=1, then returns to IDLE. A back-to-back byte starts its START bit the clock after STOP ends; no extra idle.
- RX FSM, states IDLE, START, DATA, STOP, on the 2-flop synchronized rxd:
  - IDLE: on sync rxd==0, wait DIVISOR/2 (integer) clocks, go to START.
  - START: if rxd still 0, go to DATA with a full-DIVISOR counter; otherwise it was a false start, return to IDLE.
  - DATA: sample 8 bits LSB first at each DIVISOR expiry.
  - STOP: if the sample is 1, push the byte; if the RX FIFO is full, drop it and set RXOVF. If the sample is 0, discard the byte and set FERR.
  - After STOP, go to IDLE immediately; the next falling edge is detected normally.
- Latency:
  - TX: txd falls 1 clock after the accepting write edge when idle.
  - RX: rx_valid rises 1 clock after the stop-bit sample.
- Reset mid-frame: both FSMs abort immediately and txd returns to 1 asynchronously.

Optional Feature:
- Macro: WB_UART_LOOPBACK_EN.
- When defined: adds STATUS bit 6 (LOOP, R/W, reset 0). With LOOP=1, the RX synchronizer input is the internal txd instead of the rxd port; the txd port still drives normally.
- When undefined: bit 6 reads 0, writes are ignored, and no mux is present.

Decomposition:
- Shared package/header `wb_uart_defs`:
  - register offsets (DATA=0, STATUS=1)
  - status bit indices
  - TX/RX state encodings (2-bit: IDLE=0, START=1, DATA=2, STOP=3).
- Sub-module wb_uart_fifo: sync FIFO, parameters WIDTH=8 and ABITS, with push/pop/full/empty/head. Instantiated twice (TX and RX).
- Baud counters and FSMs stay inline.

Test Plan:
- TX basic: DIVISOR=8, write 0x000000A5 to offset 0 -> txd low for 8 clocks starting 1 clock after the write, then bits 1,0,1,0,0,1,0,1, then high for 8 clocks; tx_idle=1 afterward.
- TX FIFO full: 9 writes back-to-back with FIFO_ABITS=3 while the shifter is busy -> the 9th byte is dropped and TXOVF=1. Line shows the first 9 accepted bytes in order (1 in the shifter + 8 queued), no gaps. Write 0x20 to STATUS -> TXOVF=0.
- RX basic: drive 0x3C frame on rxd at DIVISOR clocks/bit -> STATUS bit0=1; DATA read returns 0x0000003C, then STATUS bit0=0; DATA read again returns 0.
- RX errors:
  - stop bit 0 -> FERR=1, FIFO unchanged.
  - 9 frames with no reads -> 8 stored, RXOVF=1.
  - 0.3-bit low glitch -> nothing received.
- Bus: dat_o==0 and ack_o==0 whenever cyc_i=0 or stb_i=0. DATA write with sel_i=4'b1110 -> no push.
- Reset mid-TX frame (reset=0 for 2 clocks) -> txd=1 asynchronously, FIFOs empty, STATUS reads 0x00000004. Under WB_UART_LOOPBACK_EN with LOOP=1, writing 0x5A -> DATA reads 0x5A after 10*DIVISOR+4 clocks.
